// File: rtl/salu_pkg.sv
// Shared types and constants for the CLO/CLZ issue controller.
package salu_pkg;

    // Controller states:
    //   IDLE  | ready for a new CLO/CLZ request
    //   ISSUE | one-cycle start pulse to the unit, busy not yet meaningful
    //   WAIT  | unit counting, watchdog running
    //   DONE  | result held for writeback
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } salu_ctrl_state_e;

    // Largest count the unit can legally return (all-ones CLO / all-zeros CLZ).
    localparam int          SALU_MAX_COUNT  = 32;
    // Result reported to writeback when the unit never drops busy.
    localparam logic [31:0] SALU_ERR_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/salu_watchdog.sv
// Up-counting watchdog: runs while enabled, flags the final permitted cycle.
module salu_watchdog #(
    parameter int CYCLES = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    localparam int                CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0]  TERM  = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles; hold at the terminal value until cleared.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_term) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Terminal flag marks the CYCLES-th enabled cycle.
    assign o_term = i_en && (r_count == TERM);

endmodule

// File: rtl/salu_issue_ctrl.sv
// Execute-stage controller wrapping the multi-cycle CLO/CLZ unit:
// request handshake -> start pulse -> busy tracking -> result handshake.
module salu_issue_ctrl
    import salu_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 40,
    parameter int DEST_W          = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_clo,
    input  logic [31:0]       in_operand,
    input  logic [DEST_W-1:0] in_dest,
    output logic              salu_clo,
    output logic              salu_clz,
    output logic [31:0]       salu_a,
    output logic              salu_flush,
    input  logic [31:0]       salu_r,
    input  logic              salu_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              stall,
    output logic              wd_error
);

    // A watchdog shorter than the longest legal busy phase would flag good
    // operations, so it is never allowed below that bound.
    localparam int WD_CYCLES = (WATCHDOG_CYCLES < SALU_MAX_COUNT + 2) ?
                               SALU_MAX_COUNT + 2 : WATCHDOG_CYCLES;

    salu_ctrl_state_e  r_state;
    salu_ctrl_state_e  w_next_state;
    logic              w_accept;
    logic              w_wd_term;
    logic              w_in_wait;

    logic [31:0]       r_operand;
    logic              r_is_clo;
    logic [DEST_W-1:0] r_dest;
    logic [31:0]       r_result;
    logic              r_wd_error;

    assign w_in_wait = (r_state == WAIT);

    salu_watchdog #(
        .CYCLES (WD_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (!w_in_wait || flush),
        .i_en   (w_in_wait),
        .o_term (w_wd_term)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and all handshake/control outputs.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        in_ready     = 1'b0;
        salu_clo     = 1'b0;
        salu_clz     = 1'b0;
        out_valid    = 1'b0;
        stall        = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                // Busy is still low here; the unit raises it one cycle later.
                salu_clo     = r_is_clo;
                salu_clz     = !r_is_clo;
                stall        = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (!salu_busy || w_wd_term) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                stall     = !out_ready;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase

        // The unit re-triggers on a level, so a start must never survive a
        // flush or reset cycle.
        if (flush || reset) begin
            salu_clo = 1'b0;
            salu_clz = 1'b0;
        end

        if (flush) begin
            w_accept     = 1'b0;
            out_valid    = 1'b0;
            w_next_state = IDLE;
        end
    end

    assign salu_flush = flush || reset;
    assign salu_a     = r_operand;
    assign out_result = r_result;
    assign out_dest   = r_dest;
    assign wd_error   = r_wd_error;

    // Request capture, result capture and the sticky watchdog error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_operand  <= '0;
            r_is_clo   <= 1'b0;
            r_dest     <= '0;
            r_result   <= '0;
            r_wd_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_operand <= in_operand;
                r_is_clo  <= in_is_clo;
                r_dest    <= in_dest;
            end
            if (w_in_wait && !flush) begin
                if (!salu_busy) begin
                    r_result <= salu_r;
                end else if (w_wd_term) begin
                    r_result   <= SALU_ERR_RESULT;
                    r_wd_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_salu_issue_ctrl.sv
// Bench for salu_issue_ctrl with a behavioural CLO/CLZ unit model and a
// result scoreboard.
module tb_salu_issue_ctrl;

    localparam int WD     = 40;
    localparam int DEST_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_is_clo;
    logic [31:0]       in_operand;
    logic [DEST_W-1:0] in_dest;
    logic              salu_clo;
    logic              salu_clz;
    logic [31:0]       salu_a;
    logic              salu_flush;
    logic [31:0]       salu_r;
    logic              salu_busy;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [DEST_W-1:0] out_dest;
    logic              stall;
    logic              wd_error;

    always #5 clk = ~clk;

    salu_issue_ctrl #(
        .WATCHDOG_CYCLES (WD),
        .DEST_W          (DEST_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_is_clo  (in_is_clo),
        .in_operand (in_operand),
        .in_dest    (in_dest),
        .salu_clo   (salu_clo),
        .salu_clz   (salu_clz),
        .salu_a     (salu_a),
        .salu_flush (salu_flush),
        .salu_r     (salu_r),
        .salu_busy  (salu_busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest),
        .stall      (stall),
        .wd_error   (wd_error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lead_count(input logic is_clo, input logic [31:0] v);
        logic [31:0] n;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i] != is_clo) break;
            n++;
        end
        return n;
    endfunction

    // Unit model: start seen at an edge -> busy for count+1 cycles, result valid.
    int          m_cnt = 0;
    logic [31:0] m_r = 32'h0;
    bit          stuck_mode = 1'b0;

    always @(posedge clk) begin
        if (salu_flush) begin
            m_cnt <= 0;
        end else if (salu_clo || salu_clz) begin
            m_r   <= lead_count(salu_clo, salu_a);
            m_cnt <= stuck_mode ? 1000000 : int'(lead_count(salu_clo, salu_a)) + 1;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign salu_busy = (m_cnt != 0);
    assign salu_r    = m_r;

    // Scoreboard: push on accepted request, pop on result handshake.
    typedef struct packed {
        logic [31:0]       res;
        logic [DEST_W-1:0] dest;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_result", out_result, e.res);
                    check("sb_dest", 32'(out_dest), 32'(e.dest));
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back('{res:  stuck_mode ? 32'hFFFF_FFFF : lead_count(in_is_clo, in_operand),
                                 dest: in_dest});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag, input logic exp_flush);
        check({tag, "_in_ready"},   32'(in_ready),   32'd1);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_out_result"}, out_result,      32'd0);
        check({tag, "_out_dest"},   32'(out_dest),   32'd0);
        check({tag, "_salu_clo"},   32'(salu_clo),   32'd0);
        check({tag, "_salu_clz"},   32'(salu_clz),   32'd0);
        check({tag, "_salu_a"},     salu_a,          32'd0);
        check({tag, "_salu_flush"}, 32'(salu_flush), 32'(exp_flush));
        check({tag, "_stall"},      32'(stall),      32'd0);
        check({tag, "_wd_error"},   32'(wd_error),   32'd0);
    endtask

    // Present one request, check the start pulse, and run until DONE.
    task automatic issue_and_wait(input logic is_clo, input logic [31:0] op,
                                  input logic [DEST_W-1:0] dest, output bit ok);
        int k;
        int n;
        int pulses;
        int bad;
        int exp_wait;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        in_valid   = 1'b1;
        in_is_clo  = is_clo;
        in_operand = op;
        in_dest    = dest;
        #1;
        check("pre_in_ready", 32'(in_ready), 32'd1);
        check("pre_pulse", 32'(salu_clo || salu_clz), 32'd0);
        tick();
        in_valid   = 1'b0;
        in_operand = $urandom;
        in_dest    = DEST_W'($urandom);
        #1;
        check("issue_clo", 32'(salu_clo), 32'(is_clo));
        check("issue_clz", 32'(salu_clz), 32'(!is_clo));
        check("issue_a", salu_a, op);
        check("issue_stall", 32'(stall), 32'd1);
        check("issue_in_ready", 32'(in_ready), 32'd0);
        exp_wait = stuck_mode ? WD : int'(lead_count(is_clo, op)) + 2;
        n = 0;
        pulses = 0;
        bad = 0;
        tick();
        while (!out_valid && n < 200) begin
            n++;
            if (salu_clo || salu_clz) pulses++;
            if (!stall || in_ready) bad++;
            tick();
        end
        check("wait_cycles", 32'(n), 32'(exp_wait));
        check("wait_pulses", 32'(pulses), 32'd0);
        check("wait_stall", 32'(bad), 32'd0);
        ok = out_valid;
    endtask

    // Full request with a programmable writeback hold time in DONE.
    task automatic do_req(input logic is_clo, input logic [31:0] op,
                          input logic [DEST_W-1:0] dest, input int hold);
        bit          ok;
        logic [31:0] e_res;
        issue_and_wait(is_clo, op, dest, ok);
        if (!ok) return;
        e_res = stuck_mode ? 32'hFFFF_FFFF : lead_count(is_clo, op);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", out_result, e_res);
            check("hold_dest", 32'(out_dest), 32'(dest));
            check("hold_stall", 32'(stall), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_is_clo  = 1'b1;
        in_operand = 32'hFFFF_FFFF;
        #1;
        check("rel_valid", 32'(out_valid), 32'd1);
        check("rel_stall", 32'(stall), 32'd0);
        check("rel_in_ready", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("no_bypass", 32'(salu_clo || salu_clz), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        bit ok;
        int vcount;
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_is_clo  = 1'b0;
        in_operand = '0;
        in_dest    = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst", 1'b1);
        reset = 1'b0;
        #1;
        check_reset_outputs("post_rst", 1'b0);

        do_req(1'b0, 32'h0001_0000, 5'd7, 1);
        do_req(1'b1, 32'hF000_0000, 5'd12, 0);
        do_req(1'b1, 32'hFFFF_FFFF, 5'd31, 1);
        do_req(1'b0, 32'h0000_0001, 5'd5, 5);
        do_req(1'b0, 32'h8000_0000, 5'd1, 0);
        do_req(1'b1, 32'h7FFF_FFFF, 5'd2, 0);
        do_req(1'b0, 32'h0000_0000, 5'd3, 2);
        for (int i = 0; i < 6; i++) begin
            logic        c;
            logic [31:0] v;
            c = 1'($urandom_range(0, 1));
            v = $urandom >> $urandom_range(0, 31);
            if (c) v = ~v;
            do_req(c, v, DEST_W'($urandom), $urandom_range(0, 2));
        end

        // Request coinciding with flush in IDLE is dropped.
        in_valid   = 1'b1;
        in_is_clo  = 1'b0;
        in_operand = 32'h0;
        flush      = 1'b1;
        #1;
        check("flush_idle_pt", 32'(salu_flush), 32'd1);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check("flush_drop_ready", 32'(in_ready), 32'd1);
        check("flush_drop_pulse", 32'(salu_clo || salu_clz), 32'd0);
        check("flush_drop_stall", 32'(stall), 32'd0);

        // Flush three cycles into WAIT kills the operation.
        in_valid   = 1'b1;
        in_is_clo  = 1'b0;
        in_operand = 32'h0;
        in_dest    = 5'd9;
        tick();
        in_valid = 1'b0;
        #1;
        check("fw_issue_clz", 32'(salu_clz), 32'd1);
        tick();
        tick();
        tick();
        flush = 1'b1;
        #1;
        check("fw_salu_flush", 32'(salu_flush), 32'd1);
        check("fw_valid", 32'(out_valid), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fw_in_ready", 32'(in_ready), 32'd1);
        vcount = 0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) vcount++;
            tick();
        end
        check("fw_no_valid", 32'(vcount), 32'd0);
        do_req(1'b0, 32'h00FF_0000, 5'd4, 0);

        // Unit stuck busy: watchdog fires, error is sticky across flush.
        check("wd_pre", 32'(wd_error), 32'd0);
        stuck_mode = 1'b1;
        do_req(1'b0, 32'h1234_5678, 5'd6, 2);
        check("wd_set", 32'(wd_error), 32'd1);
        stuck_mode = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("wd_after_flush", 32'(wd_error), 32'd1);
        do_req(1'b1, 32'hC000_0000, 5'd8, 0);
        check("wd_still_set", 32'(wd_error), 32'd1);

        // Reset while a result is pending in DONE.
        issue_and_wait(1'b0, 32'h0000_FFFF, 5'd10, ok);
        check("rd_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_done", 1'b1);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_done_rel", 1'b0);
        do_req(1'b0, 32'h0000_0400, 5'd17, 1);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
